// File: rtl/uart_tx_responder.sv
// uart_tx_responder: byte FIFO feeding an 8N1 UART serializer (idle-high txd).
// Ports: clock, reset(async low), send_en/send_data in, send_busy/pending/txd out.
module uart_tx_responder #(
  parameter int CLK_PER_BIT = 100,
  parameter int DEPTH       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     send_en,
  input  logic [7:0]               send_data,
  output logic                     send_busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     txd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_txd;
  logic [AW:0]   r_pending;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic [7:0]    w_rd;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shreg_nxt;
  logic          w_txd_nxt;
  logic [AW:0]   w_wp_nxt;
  logic [AW:0]   w_rp_nxt;
  logic [AW:0]   w_pend_nxt;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = send_en && !w_full;
  assign w_rd    = r_mem[r_rp[AW-1:0]];
  assign w_tick  = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tick ? CNT_MAX : r_cnt - 1'b1;
    end
    unique case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_rd;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_cnt_nxt   = CNT_MAX;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shreg[0];
          w_bit_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_shreg_nxt = r_shreg >> 1;
            w_txd_nxt   = r_shreg[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // Chain straight into the next start bit: no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shreg_nxt = w_rd;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign w_wp_nxt   = r_wp + (AW+1)'(w_push);
  assign w_rp_nxt   = r_rp + (AW+1)'(w_pop);
  assign w_pend_nxt = (w_wp_nxt - w_rp_nxt) +
                      (AW+1)'(w_state_nxt != S_IDLE);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= send_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_txd     <= 1'b1;
      r_pending <= '0;
    end else begin
      r_wp      <= w_wp_nxt;
      r_rp      <= w_rp_nxt;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_txd     <= w_txd_nxt;
      r_pending <= w_pend_nxt;
    end
  end

  assign send_busy = w_full;
  assign pending   = r_pending;
  assign txd       = r_txd;

endmodule
